// File: rtl/ticsat_skew_feeder_if.sv
// Bus-side and array-side signals of the TicSAT skew feeder, grouped for the feeder and its driver.
// issue is accepted on a clock edge where issue && issue_ready; sa_valid has no ready, so the array throttles everything through stall.
interface ticsat_skew_feeder_if #(
    parameter int SA_SIZE    = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int IDX_W = $clog2(SA_SIZE);

    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  issue;
    logic                  issue_ready;
    logic                  stall;
    logic                  clear;
    logic [DATA_WIDTH-1:0] sa_data [SA_SIZE];
    logic [SA_SIZE-1:0]    sa_valid;
    logic                  busy;
    logic                  err;
    // Debug view of which staging rows currently hold a fresh word.
    logic [SA_SIZE-1:0]    staged_mask;

    modport master (
        output wr_en, wr_idx, wr_data, issue, stall, clear,
        input  issue_ready, sa_data, sa_valid, busy, err, staged_mask
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, issue, stall, clear,
        output issue_ready, sa_data, sa_valid, busy, err, staged_mask
    );
endinterface

// File: rtl/ticsat_skew_feeder.sv
// Stages one activation vector by index, then launches it into per-row delay lines of depth row+1
// so row r reaches the systolic array r cycles after row 0.
module ticsat_skew_feeder #(
    parameter int SA_SIZE    = 8,
    parameter int DATA_WIDTH = 32
) (
    input logic                 clk,
    input logic                 resetn,
    ticsat_skew_feeder_if.slave bus
);
    localparam int IDX_W = $clog2(SA_SIZE);
    localparam logic [IDX_W:0] ROWS = (IDX_W + 1)'(SA_SIZE);

    logic [DATA_WIDTH-1:0] stage_q [SA_SIZE];
    logic [SA_SIZE-1:0]    mask_q, mask_d;
    logic [SA_SIZE-1:0]    row_busy;
    logic                  err_q, err_d;
    logic                  idx_ok, wr_ok, launch;

    assign idx_ok          = {1'b0, bus.wr_idx} < ROWS;
    assign wr_ok           = bus.wr_en && idx_ok && !bus.clear;
    assign bus.issue_ready = (&mask_q) && !bus.stall && !bus.clear;
    assign launch          = bus.issue && bus.issue_ready;

    // A write in the launch cycle belongs to the next vector, so it lands on an emptied mask.
    always_comb begin
        mask_d = launch ? '0 : mask_q;
        for (int r = 0; r < SA_SIZE; r++) begin
            if (wr_ok && bus.wr_idx == IDX_W'(r)) begin
                mask_d[r] = 1'b1;
            end
        end
        err_d = err_q || (bus.wr_en && !idx_ok)
                      || (bus.issue && !bus.issue_ready && !bus.stall);
        if (bus.clear) begin
            mask_d = '0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mask_q <= '0;
            err_q  <= 1'b0;
            for (int r = 0; r < SA_SIZE; r++) begin
                stage_q[r] <= '0;
            end
        end else begin
            mask_q <= mask_d;
            err_q  <= err_d;
            for (int r = 0; r < SA_SIZE; r++) begin
                if (wr_ok && bus.wr_idx == IDX_W'(r)) begin
                    stage_q[r] <= bus.wr_data;
                end
            end
        end
    end

    for (genvar r = 0; r < SA_SIZE; r++) begin : g_row
        logic [r:0]                 vld_q;
        logic [r:0][DATA_WIDTH-1:0] dat_q;

        // Idle cycles inject zero data so the array sees 0 whenever valid is low.
        always_ff @(posedge clk) begin
            if (!resetn || bus.clear) begin
                vld_q <= '0;
                dat_q <= '0;
            end else if (!bus.stall) begin
                vld_q[0] <= launch;
                dat_q[0] <= launch ? stage_q[r] : '0;
                for (int s = 1; s <= r; s++) begin
                    vld_q[s] <= vld_q[s-1];
                    dat_q[s] <= dat_q[s-1];
                end
            end
        end

        assign bus.sa_valid[r] = vld_q[r];
        assign bus.sa_data[r]  = dat_q[r];
        assign row_busy[r]     = |vld_q;
    end

    assign bus.busy        = |row_busy;
    assign bus.err         = err_q;
    assign bus.staged_mask = mask_q;
endmodule

// File: tb/tb_ticsat_skew_feeder.sv
// Self-checking bench for ticsat_skew_feeder with a non-power-of-two array (5 rows).
// Accepted vectors are queued per row with their expected arrival tag and checked as the words emerge.
module tb_ticsat_skew_feeder;
    localparam int SA = 5;
    localparam int DW = 32;
    localparam int IW = $clog2(SA);

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    ticsat_skew_feeder_if #(.SA_SIZE(SA), .DATA_WIDTH(DW)) bus ();

    ticsat_skew_feeder #(.SA_SIZE(SA), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard state: entry = {arrival tag, data}; tag counts non-stalled edges.
    logic [63:0]   exp_q [SA][$];
    logic [DW-1:0] vec_model [SA];
    logic [DW-1:0] exp_d [SA];
    logic [SA-1:0] exp_v = '0;
    int            adv = 0;
    int            edge_kind = 2;
    bit            mon_en = 1'b0;
    bit            exp_accept = 1'b0;
    bit            busy_exp;

    always @(posedge clk) begin
        mon_en = 1'b1;
        if (!resetn) begin
            edge_kind = 2;
            for (int r = 0; r < SA; r++) begin
                exp_q[r].delete();
                vec_model[r] = '0;
            end
        end else if (bus.clear) begin
            edge_kind = 2;
            for (int r = 0; r < SA; r++) exp_q[r].delete();
        end else begin
            edge_kind = bus.stall ? 1 : 0;
            if (!bus.stall) begin
                adv++;
                if (bus.issue && exp_accept) begin
                    for (int r = 0; r < SA; r++) exp_q[r].push_back({32'(adv + r), vec_model[r]});
                end
            end
            if (bus.wr_en && int'(bus.wr_idx) < SA) vec_model[bus.wr_idx] = bus.wr_data;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int r = 0; r < SA; r++) begin
                if (edge_kind == 2) begin
                    exp_v[r] = 1'b0;
                    exp_d[r] = '0;
                end else if (edge_kind == 0) begin
                    if (exp_q[r].size() > 0 && exp_q[r][0][63:32] == 32'(adv)) begin
                        exp_v[r] = 1'b1;
                        exp_d[r] = exp_q[r][0][31:0];
                    end else begin
                        exp_v[r] = 1'b0;
                        exp_d[r] = '0;
                    end
                end
            end
            busy_exp = (exp_v != '0);
            for (int r = 0; r < SA; r++) if (exp_q[r].size() > 0) busy_exp = 1'b1;
            check("sa_valid", 64'(bus.sa_valid), 64'(exp_v));
            check("busy", 64'(bus.busy), 64'(busy_exp));
            for (int r = 0; r < SA; r++) begin
                check($sformatf("sa_data[%0d]", r), 64'(bus.sa_data[r]), 64'(exp_d[r]));
                if (edge_kind == 0 && exp_v[r]) void'(exp_q[r].pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int idx, input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_idx  = IW'(idx);
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic fill(input logic [DW-1:0] base);
        for (int i = 0; i < SA; i++) write(i, base + DW'(i));
    endtask

    task automatic fill_random();
        for (int i = 0; i < SA; i++) write(i, DW'($urandom_range(32'h0FFF_FFFF, 1)));
    endtask

    task automatic issue_cycle(input bit acc, input bit wr, input int idx, input logic [DW-1:0] d);
        bus.issue   = 1'b1;
        exp_accept  = acc;
        bus.wr_en   = wr;
        bus.wr_idx  = IW'(idx);
        bus.wr_data = d;
        tick();
        bus.issue   = 1'b0;
        bus.wr_en   = 1'b0;
        exp_accept  = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    initial begin
        resetn      = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_idx  = '0;
        bus.wr_data = '0;
        bus.issue   = 1'b0;
        bus.stall   = 1'b0;
        bus.clear   = 1'b0;
        repeat (2) tick();
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_ready", 64'(bus.issue_ready), 64'd0);
        check("rst_mask", 64'(bus.staged_mask), 64'd0);
        resetn = 1'b1;
        tick();

        // Full vector, plain issue, drain.
        fill(32'h10);
        check("full_ready", 64'(bus.issue_ready), 64'd1);
        bus.stall = 1'b1;
        #1 check("ready_stall", 64'(bus.issue_ready), 64'd0);
        bus.stall = 1'b0;
        bus.clear = 1'b1;
        #1 check("ready_clear", 64'(bus.issue_ready), 64'd0);
        bus.clear = 1'b0;
        issue_cycle(1'b1, 1'b0, 0, '0);
        check("mask_after_issue", 64'(bus.staged_mask), 64'd0);
        repeat (SA + 2) tick();
        check("err_clean", 64'(bus.err), 64'd0);

        // Incomplete vector is refused and flags err.
        write(0, 32'hA0);
        write(1, 32'hA1);
        write(2, 32'hA2);
        check("partial_ready", 64'(bus.issue_ready), 64'd0);
        check("partial_mask", 64'(bus.staged_mask), 64'h07);
        issue_cycle(1'b0, 1'b0, 0, '0);
        check("partial_err", 64'(bus.err), 64'd1);
        repeat (SA + 1) tick();
        do_clear();
        check("clear_err", 64'(bus.err), 64'd0);
        check("clear_mask", 64'(bus.staged_mask), 64'd0);

        // Issue with a same-cycle write of the next vector, then issue that vector.
        fill_random();
        issue_cycle(1'b1, 1'b1, 0, DW'($urandom_range(32'h0FFF_FFFF, 1)));
        check("next_mask", 64'(bus.staged_mask), 64'h01);
        for (int i = 1; i < SA; i++) write(i, DW'($urandom_range(32'h0FFF_FFFF, 1)));
        issue_cycle(1'b1, 1'b0, 0, '0);
        repeat (SA + 2) tick();
        check("b2b_err", 64'(bus.err), 64'd0);

        // Stall for two edges mid-flight; an issue during stall is ignored without err.
        fill(32'h40);
        issue_cycle(1'b1, 1'b0, 0, '0);
        bus.stall = 1'b1;
        issue_cycle(1'b0, 1'b0, 0, '0);
        tick();
        bus.stall = 1'b0;
        check("stall_err", 64'(bus.err), 64'd0);
        repeat (SA + 3) tick();

        // Out-of-range indices are dropped and flag err.
        write(1, 32'h55);
        write(6, 32'h66);
        check("badidx_err", 64'(bus.err), 64'd1);
        check("badidx_mask", 64'(bus.staged_mask), 64'h02);
        write(5, 32'h77);
        check("badidx5_mask", 64'(bus.staged_mask), 64'h02);
        do_clear();
        check("badidx_clear", 64'(bus.err), 64'd0);

        // Issue and write of row 2 together: old vector leaves, only bit 2 remains staged.
        fill(32'h60);
        issue_cycle(1'b1, 1'b1, 2, 32'hABCD);
        check("iw_mask", 64'(bus.staged_mask), 64'h04);
        check("iw_ready", 64'(bus.issue_ready), 64'd0);
        check("iw_err", 64'(bus.err), 64'd0);
        repeat (SA + 1) tick();

        // Flush mid-flight by clear, then by reset.
        fill(32'h70);
        issue_cycle(1'b1, 1'b0, 0, '0);
        tick();
        do_clear();
        repeat (SA + 1) tick();
        check("flush_busy", 64'(bus.busy), 64'd0);
        fill(32'h80);
        issue_cycle(1'b1, 1'b0, 0, '0);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("rst2_mask", 64'(bus.staged_mask), 64'd0);
        repeat (SA + 1) tick();
        check("rst2_busy", 64'(bus.busy), 64'd0);

        for (int r = 0; r < SA; r++) check($sformatf("q_empty[%0d]", r), 64'(exp_q[r].size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
